// File: rtl/string_run_expander.sv
// string_run_expander: run-length decoder for the string-compression path.
// Takes {string, count} records and re-emits each string `count` times, one
// copy per accepted output beat. When a run ends and the next record is
// already waiting, the next run starts on the same edge with no idle cycle.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   in_record        [REC_W-1:CNT_W] string, [CNT_W-1:0] run count
//   in_valid/ready   input handshake (in_ready is combinational)
//   out_string       current string copy
//   out_valid/ready  output handshake
//   out_last         high on the final copy of the current run
//   busy             a run is in progress
//   zero_drops       saturating count of records received with count == 0
module string_run_expander #(
    parameter int unsigned STR_W = 128,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ZD_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [STR_W+CNT_W-1:0]   in_record,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [STR_W-1:0]         out_string,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic [ZD_W-1:0]          zero_drops
);

    localparam int unsigned REC_W = STR_W + CNT_W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [STR_W-1:0]   out_string_q, out_string_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [ZD_W-1:0]    zero_drops_q, zero_drops_d;
    logic               busy_q, busy_d;

    logic [STR_W-1:0]   rec_str;
    logic [CNT_W-1:0]   rec_cnt;
    logic               rec_zero;
    logic               out_xfer;
    logic               in_xfer;
    logic [ZD_W-1:0]    zero_drops_inc;

    assign rec_str  = in_record[REC_W-1:CNT_W];
    assign rec_cnt  = in_record[CNT_W-1:0];
    assign rec_zero = (rec_cnt == '0);
    assign out_xfer = out_valid_q && out_ready;
    assign in_xfer  = in_valid && in_ready;

    // Saturating increment: holds at all-ones.
    assign zero_drops_inc = (zero_drops_q == {ZD_W{1'b1}}) ? zero_drops_q
                                                           : zero_drops_q + ZD_W'(1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_string_q <= '0;
            remaining_q  <= '0;
            zero_drops_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_string_q <= out_string_d;
            remaining_q  <= remaining_d;
            zero_drops_q <= zero_drops_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and in_ready.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_string_d = out_string_q;
        remaining_d  = remaining_q;
        zero_drops_d = zero_drops_q;
        // out_last_q is only set while remaining==1, so it marks the final copy.
        in_ready     = (state_q == IDLE) || (out_xfer && out_last_q);

        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    if (rec_zero) begin
                        zero_drops_d = zero_drops_inc;
                    end else begin
                        state_d      = EMIT;
                        out_valid_d  = 1'b1;
                        out_string_d = rec_str;
                        remaining_d  = rec_cnt;
                        out_last_d   = (rec_cnt == CNT_W'(1));
                    end
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    if (remaining_q > CNT_W'(1)) begin
                        remaining_d = remaining_q - CNT_W'(1);
                        out_last_d  = (remaining_q == CNT_W'(2));
                    end else if (in_valid && !rec_zero) begin
                        // Back-to-back run: load on the same edge as the last copy.
                        out_string_d = rec_str;
                        remaining_d  = rec_cnt;
                        out_last_d   = (rec_cnt == CNT_W'(1));
                    end else begin
                        if (in_valid) begin
                            zero_drops_d = zero_drops_inc;
                        end
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == EMIT);
    end

    assign out_string = out_string_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign zero_drops = zero_drops_q;

endmodule
